// File: rtl/led_bar_sequencer.sv
// LED bar animation sequencer: free-running timebase, heartbeat LED and FILL/SCAN/BLINK/HOLD bar patterns.
// Define LED_BAR_PWM_EN to dim the bar with the 4-bit BRIGHT duty level.
module led_bar_sequencer #(
   parameter int WIDTH     = 8,
   parameter int CNT_W     = 26,
   parameter int STEP_BITS = 14
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [1:0]       MODE,
   input  logic [3:0]       BRIGHT,
   output logic             LED,
   output logic [WIDTH-1:0] LED_BAR,
   output logic             STEP_TICK
);

   localparam int PW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
   localparam logic [PW-1:0] POS_ONE = PW'(1);

   typedef enum logic [1:0] {
      MODE_FILL  = 2'b00,
      MODE_SCAN  = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_HOLD  = 2'b11
   } mode_e;

   mode_e            mode;
   mode_e            modePrev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stepTick_q;
   logic [PW-1:0]    pos_q, pos_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [WIDTH-1:0] ledBar_q, ledBar_d;
   logic             step;
   logic             modeChange;
   logic [PW-1:0]    patPos;
   logic             pwmGate;

   assign mode       = mode_e'(MODE);
   assign cnt_d      = cnt_q + CNT_W'(1);
   assign step       = &cnt_q[STEP_BITS-1:0];
   assign modeChange = (mode != modePrev_q);

   assign LED       = cnt_q[CNT_W-1] & cnt_q[CNT_W-5];
   assign LED_BAR   = ledBar_q;
   assign STEP_TICK = stepTick_q;

`ifdef LED_BAR_PWM_EN
   assign pwmGate = (cnt_q[3:0] < BRIGHT);
`else
   // BRIGHT has no effect here; the OR keeps the gate permanently open.
   assign pwmGate = 1'b1 | (^BRIGHT);
`endif

   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      if (modeChange && (mode != MODE_HOLD)) begin
         pos_d = '0;
         dir_d = 1'b0;
      end else if (step && EN) begin
         case (mode)
            MODE_FILL: begin
               dir_d = 1'b0;
               pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
            end
            MODE_SCAN: begin
               if (!dir_q) begin
                  if (pos_q == POS_MAX) begin
                     dir_d = 1'b1;
                     pos_d = pos_q - POS_ONE;
                  end else begin
                     pos_d = pos_q + POS_ONE;
                  end
               end else begin
                  if (pos_q == '0) begin
                     dir_d = 1'b0;
                     pos_d = pos_q + POS_ONE;
                  end else begin
                     pos_d = pos_q - POS_ONE;
                  end
               end
            end
            MODE_BLINK: begin
               dir_d = 1'b0;
               pos_d = pos_q[0] ? '0 : POS_ONE;
            end
            default: begin
               pos_d = pos_q;
               dir_d = dir_q;
            end
         endcase
      end
   end

   // A fresh mode shows its first pattern on the same clock that resets the position.
   always_comb begin
      patPos = modeChange ? '0 : pos_q;
      pat_d  = pat_q;
      case (mode)
         MODE_FILL: begin
            for (int i = 0; i < WIDTH; i++) pat_d[i] = (PW'(i) <= patPos);
         end
         MODE_SCAN: begin
            for (int i = 0; i < WIDTH; i++) pat_d[i] = (PW'(i) == patPos);
         end
         MODE_BLINK: pat_d = {WIDTH{~patPos[0]}};
         default:    pat_d = pat_q;
      endcase
      ledBar_d = ~(pat_d & {WIDTH{pwmGate}});
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q      <= '0;
         stepTick_q <= 1'b0;
         pos_q      <= '0;
         dir_q      <= 1'b0;
         modePrev_q <= MODE_FILL;
         pat_q      <= '0;
         ledBar_q   <= '1;
      end else begin
         cnt_q      <= cnt_d;
         stepTick_q <= step;
         pos_q      <= pos_d;
         dir_q      <= dir_d;
         modePrev_q <= mode;
         pat_q      <= pat_d;
         ledBar_q   <= ledBar_d;
      end
   end

endmodule

// File: tb/tb_led_bar_sequencer.sv
// Directed scoreboard bench for led_bar_sequencer (WIDTH=8, CNT_W=8, STEP_BITS=2).
// Build with LED_BAR_PWM_EN defined to exercise the dimming gate instead of the animations.
module tb_led_bar_sequencer;

   logic       CLK = 1'b0;
   logic       RST;
   logic       EN;
   logic [1:0] MODE;
   logic [3:0] BRIGHT;
   logic       LED;
   logic [7:0] LED_BAR;
   logic       STEP_TICK;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      int         sel;
      logic [7:0] exp;
   } exp_t;

   exp_t sbQ[$];

   led_bar_sequencer #(.WIDTH(8), .CNT_W(8), .STEP_BITS(2)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .EN        (EN),
      .MODE      (MODE),
      .BRIGHT    (BRIGHT),
      .LED       (LED),
      .LED_BAR   (LED_BAR),
      .STEP_TICK (STEP_TICK)
   );

   always #5 CLK = ~CLK;

   // Drives all inputs at once.
   task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] mode,
                                input logic [3:0] bright);
      RST    = rst;
      EN     = en;
      MODE   = mode;
      BRIGHT = bright;
   endtask

   // Advances n rising edges and settles 1 ns past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Queues an expectation: sel 0 = LED_BAR, 1 = STEP_TICK, 2 = LED.
   task automatic expectVal(input string tag, input int sel, input logic [7:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sbQ.push_back(e);
   endtask

   // Pops every queued expectation and compares against the DUT now.
   task automatic checkOutput();
      exp_t       e;
      logic [7:0] obs;
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         case (e.sel)
            0:       obs = LED_BAR;
            1:       obs = {7'b0, STEP_TICK};
            default: obs = {7'b0, LED};
         endcase
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   initial begin
      logic [7:0] fillSeq[8];
      int         scanSeq[19];
      logic [7:0] oneHot;
      int         litCount;

      fillSeq = '{8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'hFE};
      scanSeq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5};

      $display("[TB] start");
      applyStimulus(1'b1, 1'b1, 2'b00, 4'd15);
      tick(3);
      expectVal("reset_bar", 0, 8'hFF);
      expectVal("reset_tick", 1, 8'h00);
      expectVal("reset_led", 2, 8'h00);
      checkOutput();

`ifndef LED_BAR_PWM_EN
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd15);
      tick(1);
      expectVal("fill_first", 0, 8'hFE);
      expectVal("tick_edge1", 1, 8'h00);
      checkOutput();
      tick(2);
      expectVal("tick_edge3", 1, 8'h00);
      checkOutput();
      tick(1);
      expectVal("tick_edge4", 1, 8'h01);
      expectVal("bar_edge4", 0, 8'hFE);
      checkOutput();

      for (int k = 0; k < 8; k++) begin
         tick((k == 0) ? 1 : 4);
         expectVal($sformatf("fill_%0d", k), 0, fillSeq[k]);
         checkOutput();
      end

      tick(4);
      expectVal("fill_pos1", 0, 8'hFC);
      checkOutput();
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd15);
      for (int k = 0; k < 3; k++) begin
         tick(3);
         expectVal($sformatf("frozen_tick_%0d", k), 1, 8'h01);
         checkOutput();
         tick(1);
         expectVal($sformatf("frozen_bar_%0d", k), 0, 8'hFC);
         expectVal($sformatf("frozen_tick_low_%0d", k), 1, 8'h00);
         checkOutput();
      end
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd15);
      tick(4);
      expectVal("fill_resume", 0, 8'hF8);
      checkOutput();

      applyStimulus(1'b0, 1'b1, 2'b01, 4'd15);
      tick(1);
      expectVal("scan_start", 0, 8'hFE);
      checkOutput();
      for (int k = 0; k < 19; k++) begin
         tick((k == 0) ? 3 : 4);
         oneHot = 8'h01 << scanSeq[k];
         expectVal($sformatf("scan_%0d", k), 0, ~oneHot);
         checkOutput();
      end

      applyStimulus(1'b0, 1'b1, 2'b11, 4'd15);
      for (int k = 0; k < 10; k++) begin
         tick(4);
         expectVal($sformatf("hold_%0d", k), 0, 8'hDF);
         checkOutput();
      end
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd15);
      tick(1);
      expectVal("fill_restart", 0, 8'hFE);
      checkOutput();
      tick(3);
      expectVal("fill_after_hold", 0, 8'hFC);
      checkOutput();

      applyStimulus(1'b0, 1'b1, 2'b10, 4'd15);
      tick(1);
      expectVal("blink_lit", 0, 8'h00);
      checkOutput();
      tick(3);
      expectVal("blink_dark", 0, 8'hFF);
      checkOutput();
      tick(4);
      expectVal("blink_lit2", 0, 8'h00);
      checkOutput();
      tick(3);
      expectVal("pre_reset_tick", 1, 8'h01);
      expectVal("pre_reset_bar", 0, 8'h00);
      checkOutput();

      #2;
      RST = 1'b1;
      #1;
      expectVal("async_reset_bar", 0, 8'hFF);
      expectVal("async_reset_tick", 1, 8'h00);
      checkOutput();
      tick(1);
      RST = 1'b0;
      tick(3);
      expectVal("rerelease_tick3", 1, 8'h00);
      checkOutput();
      tick(1);
      expectVal("rerelease_tick4", 1, 8'h01);
      checkOutput();
      tick(8'h87 - 4);
      expectVal("led_off_87", 2, 8'h00);
      checkOutput();
      tick(1);
      expectVal("led_on_88", 2, 8'h01);
      checkOutput();
`else
      applyStimulus(1'b0, 1'b0, 2'b10, 4'd4);
      litCount = 0;
      for (int n = 1; n <= 32; n++) begin
         tick(1);
         expectVal($sformatf("pwm4_edge%0d", n), 0, (((n - 1) % 16) < 4) ? 8'h00 : 8'hFF);
         if (LED_BAR == 8'h00) litCount++;
         checkOutput();
      end
      checks++;
      assert (litCount === 8) else begin
         errors++;
         $error("[TB] FAIL pwm4_duty observed=%0d expected=%0d", litCount, 8);
      end
      applyStimulus(1'b0, 1'b0, 2'b10, 4'd0);
      for (int n = 0; n < 16; n++) begin
         tick(1);
         expectVal($sformatf("pwm0_%0d", n), 0, 8'hFF);
         checkOutput();
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
